muldiv_ctrl: RTL
================

// Module: muldiv_ctrl
// PURPOSE
//  Iterative multiply/divide unit with a sequencing FSM for the MIPS pipeline's HI/LO
//  ops (MULT, MULTU, DIV, DIVU). Launched from the EX stage, it runs 1 bit/cycle and
//  owns the HI/LO registers. Drives an issue-stage stall to the hazard logic while an
//  MFHI/MFLO waits on an in-flight operation.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count = WIDTH
// PORTS
//  clk              in   1      clock, all state updates on rising edge
//  reset            in   1      synchronous, active-high
//  start_ex_i       in   1      EX holds a MULT/MULTU/DIV/DIVU
//  op_ex_i          in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  rs_data_ex_i     in   WIDTH  multiplicand / dividend
//  rt_data_ex_i     in   WIDTH  multiplier / divisor
//  flush_ex_i       in   1      EX instruction squashed this cycle; blocks start
//  hilo_rd_iss_i    in   1      MFHI/MFLO in issue stage
//  busy_o           out  1      FSM not IDLE
//  stall_iss_o      out  1      hold issue stage (to hazard unit)
//  done_o           out  1      1-cycle pulse: new HI/LO visible this cycle
//  hi_o             out  WIDTH  HI register
//  lo_o             out  WIDTH  LO register
// BEHAVIOUR
//  Reset: FSM=IDLE; busy_o=0, stall_iss_o=0, done_o=0, hi_o=0, lo_o=0; internal regs cleared.
//  Reset mid-operation aborts. No partial result reaches HI/LO.
//  FSM: IDLE -> RUN -> FIN -> IDLE.
//   IDLE: accept = start_ex_i & ~flush_ex_i. On accept, latch op and the operand magnitudes
//     (signed ops take |x|, record result/remainder signs), clear acc/count, go RUN.
//   RUN: exactly WIDTH cycles, count 0..WIDTH-1, saturating compare, no wrap.
//     MUL: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
//     DIV: restoring shift-subtract, one quotient bit per cycle.
//   FIN: one cycle. Apply two's-complement sign fix, then register HI/LO.
//  Result mapping:
//   MUL: {hi,lo} = 2*WIDTH-bit product.
//   DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
//  Latency: start accepted at edge 0; RUN in cycles 1..WIDTH; FIN in cycle WIDTH+1.
//   done_o=1 and new hi_o/lo_o appear in cycle WIDTH+2 (FSM already IDLE).
//  Divide by zero (divisor==0): hi = dividend unchanged, lo = all ones.
//   Same latency, no exception raised.
//  Signed overflow (DIV of -2^(WIDTH-1) by -1): lo = -2^(WIDTH-1), hi = 0.
//  start_ex_i while busy: ignored, nothing latched. The pipeline must not issue one;
//   the bench flags it as an error.
//  Start in the done_o cycle: accepted normally (IDLE). The new result overwrites HI/LO later.
//  stall_iss_o = hilo_rd_iss_i & (busy_o | accept).
//   Combinational; 0 in the done_o cycle so MFHI/MFLO reads the new value.
//  hi_o/lo_o change only at the FIN->IDLE edge or on reset.
//  flush_ex_i never cancels an operation already in RUN/FIN.
// TESTING
//  1. MULTU 7*6 -> done_o in cycle 34 (WIDTH=32), lo=0x0000002A, hi=0; busy_o high cycles 1..33.
//  2. MULT -3*5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
//  3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
//     DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  4. DIVU 0x1234/0 -> hi=0x1234, lo=0xFFFFFFFF, done_o at cycle 34.
//  5. MFLO in issue from cycle 1 -> stall_iss_o=1 cycles 1..33, 0 in cycle 34, lo_o valid then.
//     Same-cycle start+MFLO -> stall_iss_o=1 in cycle 0.
//  6. start with flush_ex_i=1 -> stays IDLE, HI/LO unchanged.
//     Reset at cycle 10 of an op -> IDLE, hi/lo=0, no done_o.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// rtl/muldiv_ctrl.sv - iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, 1 bit per cycle
// Magnitudes are computed up front; signs are reapplied in FIN so the datapath stays unsigned.
module muldiv_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_ex_i,
   input  logic [1:0]       op_ex_i,
   input  logic [WIDTH-1:0] rs_data_ex_i,
   input  logic [WIDTH-1:0] rt_data_ex_i,
   input  logic             flush_ex_i,
   input  logic             hilo_rd_iss_i,
   output logic             busy_o,
   output logic             stall_iss_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t             state, next_state;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc, acc_next, prod_fix;
   logic [WIDTH-1:0]   opnd, quo_fix, rem_fix, mag_rs, mag_rt;
   logic [WIDTH:0]     step_sum, step_diff;
   logic               op_div, neg_res, neg_rem, div_zero;
   logic               accept, signed_op;

   assign accept      = (state == IDLE) & start_ex_i & ~flush_ex_i;
   assign busy_o      = (state != IDLE);
   assign stall_iss_o = hilo_rd_iss_i & (busy_o | accept);

   assign signed_op = ~op_ex_i[0];
   assign mag_rs    = (signed_op & rs_data_ex_i[WIDTH-1]) ? -rs_data_ex_i : rs_data_ex_i;
   assign mag_rt    = (signed_op & rt_data_ex_i[WIDTH-1]) ? -rt_data_ex_i : rt_data_ex_i;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = RUN;
         RUN:     if (count == LAST) next_state = FIN;
         FIN:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // MUL: multiplier sits in acc low half and shifts out as the product shifts in.
   // DIV: acc = {remainder, dividend/quotient}; quotient bits enter at the bottom.
   always_comb begin
      step_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      step_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
      if (!op_div)
         acc_next = {step_sum, acc[WIDTH-1:1]};
      else if (!step_diff[WIDTH])
         acc_next = {step_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
         acc_next = {acc[2*WIDTH-2:0], 1'b0};
      prod_fix = neg_res ? -acc : acc;
      quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count    <= '0;
         acc      <= '0;
         opnd     <= '0;
         op_div   <= 1'b0;
         neg_res  <= 1'b0;
         neg_rem  <= 1'b0;
         div_zero <= 1'b0;
         done_o   <= 1'b0;
         hi_o     <= '0;
         lo_o     <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               op_div   <= op_ex_i[1];
               opnd     <= op_ex_i[1] ? mag_rt : mag_rs;
               acc      <= {{WIDTH{1'b0}}, (op_ex_i[1] ? mag_rs : mag_rt)};
               neg_res  <= signed_op & (rs_data_ex_i[WIDTH-1] ^ rt_data_ex_i[WIDTH-1]);
               neg_rem  <= signed_op & rs_data_ex_i[WIDTH-1];
               div_zero <= op_ex_i[1] & (rt_data_ex_i == '0);
               count    <= '0;
            end
            RUN: begin
               acc   <= acc_next;
               count <= (count == LAST) ? count : count + CW'(1);
            end
            FIN: begin
               done_o <= 1'b1;
               if (op_div) begin
                  // A zero divisor leaves the dividend in the remainder; only LO needs forcing.
                  hi_o <= rem_fix;
                  lo_o <= div_zero ? '1 : quo_fix;
               end else begin
                  {hi_o, lo_o} <= prod_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
